// File: rtl/regbank_wb_sequencer.sv
// regbank_wb_sequencer: serialises per-instruction Rd/SP write-backs onto the register bank's single write port
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   wb_valid/wb_ready          request handshake; accepted when both are high at a rising edge
//   wb_rd_en, wb_rd, wb_data   optional destination-register write
//   wb_sp_en, wb_sp_data       optional stack-pointer update, issued after the Rd write
//   reg_w, reg_rd, reg_wdata   bank write port (RegW/Rd/wrData)
//   pending_mask               registers with a latched but not yet issued write
//   err_bad_idx                sticky flag for an out-of-range destination index
//   idle                       IDLE with nothing pending
module regbank_wb_sequencer #(
   parameter int NREG   = 17,
   parameter int SP_IDX = 16,
   parameter int DW     = 32,
   parameter int AW     = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic            wb_rd_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [DW-1:0]   wb_data,
   input  logic            wb_sp_en,
   input  logic [DW-1:0]   wb_sp_data,
   output logic            reg_w,
   output logic [AW-1:0]   reg_rd,
   output logic [DW-1:0]   reg_wdata,
   output logic [NREG-1:0] pending_mask,
   output logic            err_bad_idx,
   output logic            idle
);
   typedef enum logic [1:0] {IDLE, WR_RD, WR_SP} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] rd_q;
   logic [DW-1:0] data_q, sp_data_q;
   logic sp_en_q, accept, rd_eff, bad_idx, rd_is_sp;
   logic [NREG-1:0] mask_nxt, wb_bit, rd_bit, sp_bit;
   assign wb_ready = (state == IDLE) && !reset;
   assign accept   = wb_valid && wb_ready;
   assign rd_eff   = wb_rd_en && (wb_rd != '0) && (wb_rd < AW'(NREG));
   assign bad_idx  = wb_rd_en && (wb_rd >= AW'(NREG));
   assign idle     = (state == IDLE) && (pending_mask == '0);
   assign wb_bit   = NREG'(1) << wb_rd;
   assign rd_bit   = NREG'(1) << rd_q;
   assign sp_bit   = NREG'(1) << SP_IDX;
   // An Rd write that targets SP keeps its mask bit until the trailing SP write retires it
   assign rd_is_sp = sp_en_q && (rd_q == AW'(SP_IDX));
   always_comb begin
      state_nxt = state;
      mask_nxt  = pending_mask;
      reg_w     = 1'b0;
      reg_rd    = '0;
      reg_wdata = '0;
      case (state)
         IDLE: if (accept) begin
            state_nxt = rd_eff ? WR_RD : (wb_sp_en ? WR_SP : IDLE);
            mask_nxt  = pending_mask | (rd_eff ? wb_bit : '0) | (wb_sp_en ? sp_bit : '0);
         end
         WR_RD: begin
            reg_w     = 1'b1;
            reg_rd    = rd_q;
            reg_wdata = data_q;
            state_nxt = sp_en_q ? WR_SP : IDLE;
            mask_nxt  = rd_is_sp ? pending_mask : pending_mask & ~rd_bit;
         end
         WR_SP: begin
            reg_w     = 1'b1;
            reg_rd    = AW'(SP_IDX);
            reg_wdata = sp_data_q;
            state_nxt = IDLE;
            mask_nxt  = pending_mask & ~sp_bit;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         pending_mask <= '0;
         err_bad_idx  <= 1'b0;
         rd_q         <= '0;
         data_q       <= '0;
         sp_en_q      <= 1'b0;
         sp_data_q    <= '0;
      end else begin
         state        <= state_nxt;
         pending_mask <= mask_nxt;
         if (accept) begin
            rd_q        <= wb_rd;
            data_q      <= wb_data;
            sp_en_q     <= wb_sp_en;
            sp_data_q   <= wb_sp_data;
            err_bad_idx <= err_bad_idx | bad_idx;
         end
      end
   end
endmodule

// File: tb/tb_regbank_wb_sequencer.sv
// tb_regbank_wb_sequencer: directed checks of the write-back sequencer against hand-computed values
module tb_regbank_wb_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic        wb_rd_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        wb_sp_en = 1'b0;
   logic [31:0] wb_sp_data = '0;
   logic        reg_w;
   logic [4:0]  reg_rd;
   logic [31:0] reg_wdata;
   logic [16:0] pending_mask;
   logic        err_bad_idx;
   logic        idle;
   logic [31:0] bank [0:31];
   int checks = 0;
   int failures = 0;
   regbank_wb_sequencer dut (
      .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_sp_en(wb_sp_en), .wb_sp_data(wb_sp_data),
      .reg_w(reg_w), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
      .pending_mask(pending_mask), .err_bad_idx(err_bad_idx), .idle(idle)
   );
   always #5 clk = ~clk;
   // Register bank stand-in: captures whatever the write port presents at each edge
   always @(posedge clk) if (reg_w) bank[reg_rd] <= reg_wdata;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic req(input logic rd_en, input logic [4:0] rd, input logic [31:0] d,
                      input logic sp_en, input logic [31:0] spd);
      wb_valid = 1'b1; wb_rd_en = rd_en; wb_rd = rd; wb_data = d;
      wb_sp_en = sp_en; wb_sp_data = spd;
      tick();
      wb_valid = 1'b0; wb_rd_en = 1'b0; wb_sp_en = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) bank[i] = '0;
      tick(); tick();
      chk("rst_reg_w", 32'(reg_w), 0);
      chk("rst_reg_rd", 32'(reg_rd), 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_mask", 32'(pending_mask), 0);
      chk("rst_err", 32'(err_bad_idx), 0);
      chk("rst_ready", 32'(wb_ready), 0);
      reset = 1'b0; #1;
      chk("rst_ready_rel", 32'(wb_ready), 1);
      chk("rst_idle", 32'(idle), 1);
      req(1, 3, 42, 0, 0);
      chk("r3_reg_w", 32'(reg_w), 1);
      chk("r3_reg_rd", 32'(reg_rd), 3);
      chk("r3_wdata", reg_wdata, 42);
      chk("r3_mask", 32'(pending_mask), 32'h8);
      chk("r3_ready", 32'(wb_ready), 0);
      chk("r3_idle", 32'(idle), 0);
      tick();
      chk("r3_done_reg_w", 32'(reg_w), 0);
      chk("r3_done_idle", 32'(idle), 1);
      chk("r3_bank", bank[3], 42);
      req(1, 5, 7, 1, 1024);
      chk("pop1_reg_w", 32'(reg_w), 1);
      chk("pop1_reg_rd", 32'(reg_rd), 5);
      chk("pop1_wdata", reg_wdata, 7);
      chk("pop1_mask", 32'(pending_mask), 32'h10020);
      chk("pop1_ready", 32'(wb_ready), 0);
      tick();
      chk("pop2_reg_w", 32'(reg_w), 1);
      chk("pop2_reg_rd", 32'(reg_rd), 16);
      chk("pop2_wdata", reg_wdata, 1024);
      chk("pop2_mask", 32'(pending_mask), 32'h10000);
      chk("pop2_ready", 32'(wb_ready), 0);
      tick();
      chk("pop3_reg_w", 32'(reg_w), 0);
      chk("pop3_mask", 32'(pending_mask), 0);
      chk("pop3_ready", 32'(wb_ready), 1);
      chk("pop_bank_r5", bank[5], 7);
      chk("pop_bank_sp", bank[16], 1024);
      req(1, 0, 99, 0, 0);
      chk("r0_reg_w", 32'(reg_w), 0);
      chk("r0_err", 32'(err_bad_idx), 0);
      chk("r0_ready", 32'(wb_ready), 1);
      chk("r0_mask", 32'(pending_mask), 0);
      chk("r0_bank", bank[0], 0);
      req(1, 20, 55, 1, 900);
      chk("bad_reg_w", 32'(reg_w), 1);
      chk("bad_reg_rd", 32'(reg_rd), 16);
      chk("bad_wdata", reg_wdata, 900);
      chk("bad_err", 32'(err_bad_idx), 1);
      chk("bad_mask", 32'(pending_mask), 32'h10000);
      tick();
      chk("bad_done_reg_w", 32'(reg_w), 0);
      chk("bad_err_sticky", 32'(err_bad_idx), 1);
      chk("bad_ready", 32'(wb_ready), 1);
      chk("bad_bank_sp", bank[16], 900);
      req(1, 16, 11, 1, 22);
      chk("spsp1_reg_rd", 32'(reg_rd), 16);
      chk("spsp1_wdata", reg_wdata, 11);
      chk("spsp1_mask", 32'(pending_mask), 32'h10000);
      tick();
      chk("spsp2_reg_w", 32'(reg_w), 1);
      chk("spsp2_reg_rd", 32'(reg_rd), 16);
      chk("spsp2_wdata", reg_wdata, 22);
      chk("spsp2_mask", 32'(pending_mask), 32'h10000);
      tick();
      chk("spsp_done_reg_w", 32'(reg_w), 0);
      chk("spsp_done_mask", 32'(pending_mask), 0);
      chk("spsp_bank_sp", bank[16], 22);
      chk("spsp_err_sticky", 32'(err_bad_idx), 1);
      req(1, 7, 5, 1, 77);
      chk("rstmid_reg_w", 32'(reg_w), 1);
      chk("rstmid_mask", 32'(pending_mask), 32'h10080);
      reset = 1'b1;
      tick();
      chk("rstmid_out_reg_w", 32'(reg_w), 0);
      chk("rstmid_out_reg_rd", 32'(reg_rd), 0);
      chk("rstmid_out_wdata", reg_wdata, 0);
      chk("rstmid_out_mask", 32'(pending_mask), 0);
      chk("rstmid_out_err", 32'(err_bad_idx), 0);
      chk("rstmid_out_ready", 32'(wb_ready), 0);
      reset = 1'b0; #1;
      chk("rstmid_ready", 32'(wb_ready), 1);
      chk("rstmid_idle", 32'(idle), 1);
      tick();
      chk("rstmid_no_sp_pulse", 32'(reg_w), 0);
      chk("rstmid_bank_sp", bank[16], 22);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
